// File: rtl/word_sender_pkg.sv
// Shared types for the word sender: sequencer and transmitter state encodings.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package word_sender_pkg;

    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        WAIT = 2'd3
    } seq_state_t;

    typedef enum logic [1:0] {
        T_IDLE  = 2'd0,
        T_START = 2'd1,
        T_DATA  = 2'd2,
        T_STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/uart_transmitter.sv
// UART 8N1 transmitter: one start bit, 8 data bits LSB first, one stop bit.
// Latency: line falls on the edge that accepts tx_start; a frame is 10*CLKS_PER_BIT cycles.
// Backpressure: tx_start is taken only while tx_ready (T_IDLE); tx_done pulses on the last stop cycle.
module uart_transmitter
    import word_sender_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
)
(
    input  logic       CLK,
    input  logic       INITIALIZE,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       UART_TX
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    tx_state_t        state_q, state_d;
    logic [CNT_W-1:0] baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             line_q, line_d;
    logic             bit_end;

    assign bit_end  = (baud_q == CNT_LAST);
    assign tx_ready = (state_q == T_IDLE);
    assign tx_done  = (state_q == T_STOP) && bit_end;
    assign UART_TX  = line_q;

    // Next-state logic; the line value is computed alongside so it changes on the state edge.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q + CNT_W'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        line_d  = line_q;
        case (state_q)
            T_IDLE: begin
                baud_d = '0;
                line_d = 1'b1;
                if (tx_start) begin
                    state_d = T_START;
                    shift_d = tx_data;
                    line_d  = 1'b0;
                end
            end
            T_START: begin
                if (bit_end) begin
                    state_d = T_DATA;
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    line_d  = shift_q[0];
                end
            end
            T_DATA: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = T_STOP;
                        line_d  = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        line_d  = shift_q[1];
                    end
                end
            end
            T_STOP: begin
                if (bit_end) begin
                    state_d = T_IDLE;
                    baud_d  = '0;
                end
            end
            default: begin
                state_d = T_IDLE;
                baud_d  = '0;
                line_d  = 1'b1;
            end
        endcase
    end

    // Transmitter state; reset forces the line high immediately, aborting any frame.
    always_ff @(posedge CLK or posedge INITIALIZE) begin
        if (INITIALIZE) begin
            state_q <= T_IDLE;
            baud_q  <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            line_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            line_q  <= line_d;
        end
    end

endmodule

// File: rtl/word_sender.sv
// Buffers 32-bit words and sends each over UART as four 8N1 bytes, MSB first.
// Latency: word accepted into an idle, empty block at edge N -> UART_TX falls after edge N+3.
// Backpressure: wready = FIFO not full; producer holds wvalid/wdata. WORD_SENDER_LED_EN adds LED word counter.
module word_sender
    import word_sender_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16
)
(
    input  logic        CLK,
    input  logic        INITIALIZE,
    input  logic [31:0] wdata,
    input  logic        wvalid,
    output logic        wready,
    output logic        UART_TX,
    output logic        busy
`ifdef WORD_SENDER_LED_EN
    ,
    output logic [7:0]  LED
`endif
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    // ---------------- word FIFO ----------------
    logic [31:0]      mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push, pop;

    // ---------------- sequencer ----------------
    seq_state_t  seq_q, seq_d;
    logic [31:0] shreg_q, shreg_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic        last_byte;

    // ---------------- transmitter link ----------------
    logic tx_start, tx_ready, tx_done;

    assign wready    = (count_q != CNT_W'(FIFO_DEPTH));
    assign push      = wvalid && wready;
    assign pop       = (seq_q == IDLE) && (count_q != '0);
    assign last_byte = (byte_idx_q == 2'(BYTES_PER_WORD - 1));
    assign tx_start  = (seq_q == SEND) && tx_ready;
    assign busy      = (count_q != '0) || (seq_q != IDLE) || !tx_ready;

    // FIFO pointer and occupancy update; simultaneous push and pop leave count unchanged.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // FIFO storage; contents need no reset because occupancy is tracked by count.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    // Sequencer: pop a word, then hand its bytes to the transmitter one at a time.
    always_comb begin
        seq_d      = seq_q;
        shreg_d    = shreg_q;
        byte_idx_d = byte_idx_q;
        case (seq_q)
            IDLE: begin
                if (pop) begin
                    shreg_d    = mem_q[rd_ptr_q];
                    byte_idx_d = 2'd0;
                    seq_d      = LOAD;
                end
            end
            LOAD: seq_d = SEND;
            SEND: begin
                if (tx_ready) begin
                    seq_d = WAIT;
                end
            end
            WAIT: begin
                if (tx_done) begin
                    shreg_d    = {shreg_q[23:0], 8'h00};
                    byte_idx_d = byte_idx_q + 2'd1;
                    seq_d      = last_byte ? IDLE : SEND;
                end
            end
            default: seq_d = IDLE;
        endcase
    end

    // FIFO bookkeeping and sequencer state; reset drops every queued word.
    always_ff @(posedge CLK or posedge INITIALIZE) begin
        if (INITIALIZE) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            seq_q      <= IDLE;
            shreg_q    <= 32'h0;
            byte_idx_q <= 2'd0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            seq_q      <= seq_d;
            shreg_q    <= shreg_d;
            byte_idx_q <= byte_idx_d;
        end
    end

`ifdef WORD_SENDER_LED_EN
    logic [7:0] led_cnt_q, led_cnt_d;
    logic       word_done;

    assign word_done = (seq_q == WAIT) && tx_done && last_byte;
    assign LED       = led_cnt_q;

    // Count fully transmitted words; wraps naturally at 8 bits.
    always_comb begin
        led_cnt_d = word_done ? led_cnt_q + 8'd1 : led_cnt_q;
    end

    // LED counter register.
    always_ff @(posedge CLK or posedge INITIALIZE) begin
        if (INITIALIZE) begin
            led_cnt_q <= 8'h00;
        end else begin
            led_cnt_q <= led_cnt_d;
        end
    end
`endif

    uart_transmitter #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_tx (
        .CLK        (CLK),
        .INITIALIZE (INITIALIZE),
        .tx_data    (shreg_q[31:24]),
        .tx_start   (tx_start),
        .tx_ready   (tx_ready),
        .tx_done    (tx_done),
        .UART_TX    (UART_TX)
    );

endmodule

// File: tb/tb_word_sender.sv
// Directed + random bench for word_sender with a mid-bit sampling UART monitor.
// Latency: checks 3-edge start latency, 40-cycle frames, 1/3-cycle inter-frame gaps.
// Backpressure: checks wready stall at 16 queued words and lossless resume.
module tb_word_sender;

    localparam int CPB   = 4;
    localparam int DEPTH = 16;

    logic        CLK = 1'b0;
    logic        INITIALIZE = 1'b1;
    logic [31:0] wdata = 32'h0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic        UART_TX;
    logic        busy;
`ifdef WORD_SENDER_LED_EN
    logic [7:0]  LED;
`endif

    word_sender #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .CLK        (CLK),
        .INITIALIZE (INITIALIZE),
        .wdata      (wdata),
        .wvalid     (wvalid),
        .wready     (wready),
        .UART_TX    (UART_TX),
        .busy       (busy)
`ifdef WORD_SENDER_LED_EN
        ,
        .LED        (LED)
`endif
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    // reference model state
    logic [7:0] exp_q[$];
    int         acc_q[$];
    int         n_acc = 0;
    int         first_block_acc = -1;

    // monitor state
    logic [7:0] rx_q[$];
    int         fall_q[$];
    int         frame_err = 0;
    int         rst_gen = 0;
    int         busy_fall = -1;
    logic       busy_prev = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // UART monitor: detect falling edge, sample each bit in its middle.
    initial begin : uart_mon
        logic       prev;
        logic [7:0] b;
        int         f, g;
        logic       ok;
        prev = 1'b1;
        forever begin
            @(negedge CLK);
            if (prev && !UART_TX && !INITIALIZE) begin
                f  = cyc;
                g  = rst_gen;
                ok = 1'b1;
                repeat (CPB / 2) @(negedge CLK);
                if (UART_TX !== 1'b0) ok = 1'b0;
                for (int k = 0; k < 8; k++) begin
                    repeat (CPB) @(negedge CLK);
                    b[k] = UART_TX;
                end
                repeat (CPB) @(negedge CLK);
                if (UART_TX !== 1'b1) ok = 1'b0;
                if (g == rst_gen) begin
                    if (!ok) frame_err++;
                    rx_q.push_back(b);
                    fall_q.push_back(f);
                end
                prev = 1'b1;
            end else begin
                prev = UART_TX;
            end
        end
    end

    always @(negedge CLK) begin
        if (busy_prev && !busy) busy_fall = cyc;
        busy_prev = busy;
    end

`ifdef WORD_SENDER_LED_EN
    logic [7:0] led_prev = 8'h00;
    logic       led_watch = 1'b0;
    int         led_bad = 0;
    int         led_changes = 0;
    always @(negedge CLK) begin
        if (led_watch && LED !== led_prev) begin
            led_changes++;
            if (LED !== led_prev + 8'd1) led_bad++;
            if (fall_q.size() == 0 || (fall_q.size() % 4) != 0) led_bad++;
            else if (cyc != fall_q[fall_q.size()-1] + 10*CPB) led_bad++;
        end
        led_prev = LED;
    end
`endif

    // Present a word and hold it until accepted; model records its four bytes MSB first.
    task automatic push_word(input logic [31:0] w);
        int   n;
        logic ok;
        n = 0;
        wvalid = 1'b1;
        wdata  = w;
        forever begin
            ok = wready;
            @(posedge CLK);
            #1;
            if (ok) begin
                acc_q.push_back(cyc);
                n_acc++;
                for (int i = 3; i >= 0; i--) exp_q.push_back(w[i*8 +: 8]);
                break;
            end
            if (first_block_acc < 0) first_block_acc = n_acc;
            n++;
            if (n > 3000) begin
                check("push_accept_budget", wready, 1);
                break;
            end
            @(negedge CLK);
        end
        @(negedge CLK);
    endtask

    task automatic wait_done(input int nframes, input string tag);
        int n;
        n = 0;
        while ((fall_q.size() < nframes || busy) && n < 20000) begin
            @(negedge CLK);
            n++;
        end
        repeat (3) @(negedge CLK);
        check({tag, "_completed"}, (fall_q.size() >= nframes) && !busy, 1);
    endtask

    // Compare received bytes with the model; 'full' also demands equal counts.
    task automatic drain_check(input string tag, input bit full);
        logic [7:0] got, want;
        int         i;
        if (full) check({tag, "_byte_count"}, rx_q.size(), exp_q.size());
        i = 0;
        while (rx_q.size() > 0 && exp_q.size() > 0) begin
            got  = rx_q.pop_front();
            want = exp_q.pop_front();
            check($sformatf("%s_byte%0d", tag, i), got, want);
            i++;
        end
        rx_q.delete();
        if (full) exp_q.delete();
    endtask

    task automatic clear_hist();
        fall_q.delete();
        acc_q.delete();
        n_acc = 0;
        first_block_acc = -1;
    endtask

    initial begin : watchdog
        #3ms;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int f_before;
        logic [31:0] w;

        // ---- reset state ----
        repeat (3) @(negedge CLK);
        check("rst_uart_tx", UART_TX, 1);
        check("rst_wready", wready, 1);
        check("rst_busy", busy, 0);
`ifdef WORD_SENDER_LED_EN
        check("rst_led", LED, 0);
`endif
        INITIALIZE = 1'b0;
        repeat (2) @(negedge CLK);

        // ---- 1: single word, timing ----
        clear_hist();
        push_word(32'h12345678);
        wvalid = 1'b0;
        wait_done(4, "t1");
        check("t1_start_latency", fall_q[0] - acc_q[0], 3);
        check("t1_gap01", fall_q[1] - fall_q[0], 10*CPB + 1);
        check("t1_gap12", fall_q[2] - fall_q[1], 10*CPB + 1);
        check("t1_gap23", fall_q[3] - fall_q[2], 10*CPB + 1);
        check("t1_busy_drop", busy_fall - fall_q[3], 10*CPB);
        drain_check("t1", 1);

        // ---- 2: all-zero then all-one word back to back ----
        clear_hist();
        push_word(32'h00000000);
        push_word(32'hFFFFFFFF);
        wvalid = 1'b0;
        wait_done(8, "t2");
        check("t2_inter_word_gap", fall_q[4] - fall_q[3], 10*CPB + 3);
        check("t2_intra_word_gap", fall_q[5] - fall_q[4], 10*CPB + 1);
        check("t2_framing", frame_err, 0);
        drain_check("t2", 1);

        // ---- 3 & 5: overflow backpressure, push against full with simultaneous pop ----
        clear_hist();
        for (int i = 0; i < 20; i++) push_word(i);
        wvalid = 1'b0;
        wait_done(80, "t3");
        check("t3_words_accepted", n_acc, 20);
        check("t3_stall_after", first_block_acc, DEPTH + 1);
        check("t5_accept_after_pop_w17", acc_q[17], fall_q[4] - 1);
        check("t5_accept_after_pop_w18", acc_q[18], fall_q[8] - 1);
        check("t3_framing", frame_err, 0);
        drain_check("t3", 1);

        // ---- random words with random idle gaps ----
        clear_hist();
        for (int i = 0; i < 6; i++) begin
            push_word($urandom);
            wvalid = 1'b0;
            repeat ($urandom_range(0, 60)) @(negedge CLK);
        end
        wait_done(24, "rnd");
        check("rnd_framing", frame_err, 0);
        drain_check("rnd", 1);

        // ---- 4: reset in the middle of byte 2 ----
        clear_hist();
        push_word(32'hCAFEBABE);
        for (int i = 0; i < 3; i++) push_word($urandom);
        wvalid = 1'b0;
        begin : wait_byte2
            int n;
            n = 0;
            while (fall_q.size() < 2 && n < 2000) begin @(negedge CLK); n++; end
            n = 0;
            while (UART_TX !== 1'b0 && n < 200) begin @(negedge CLK); n++; end
        end
        check("t4_bytes_before_reset", fall_q.size(), 2);
        repeat (5) @(negedge CLK);
        check("t4_bit0_of_ba_low", UART_TX, 0);
        drain_check("t4_pre", 0);
        exp_q.delete();
        #1;
        INITIALIZE = 1'b1;
        rst_gen++;
        #1;
        check("t4_async_line_high", UART_TX, 1);
        check("t4_wready", wready, 1);
        check("t4_busy", busy, 0);
        repeat (3) @(negedge CLK);
        INITIALIZE = 1'b0;
        f_before = fall_q.size();
        repeat (200) @(negedge CLK);
        check("t4_nothing_after_reset", fall_q.size(), f_before);
        check("t4_rx_empty", rx_q.size(), 0);
        clear_hist();
        push_word(32'hA5A5A5A5);
        wvalid = 1'b0;
        wait_done(4, "t4_post");
        check("t4_post_latency", fall_q[0] - acc_q[0], 3);
        drain_check("t4_post", 1);

`ifdef WORD_SENDER_LED_EN
        // ---- 6: LED word counter wraps ----
        INITIALIZE = 1'b1;
        rst_gen++;
        repeat (2) @(negedge CLK);
        INITIALIZE = 1'b0;
        @(negedge CLK);
        check("t6_led_reset", LED, 0);
        clear_hist();
        led_watch = 1'b1;
        for (int i = 0; i < 257; i++) begin
            w = $urandom;
            push_word(w);
        end
        wvalid = 1'b0;
        wait_done(257*4, "t6");
        led_watch = 1'b0;
        check("t6_led_value", LED, 1);
        check("t6_led_changes", led_changes, 257);
        check("t6_led_timing", led_bad, 0);
        drain_check("t6", 1);
`endif

        check("final_framing", frame_err, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
